// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM write arbiter.
package sdram_arb_pkg;

   localparam int unsigned DATA_W   = 128;
   localparam int unsigned BE_W     = 16;
   localparam int unsigned NUM_RQ   = 2;
   localparam int unsigned RQ_IDX_W = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // One-hot grant vector to requester index.
   function automatic logic [RQ_IDX_W-1:0] oh2idx(input logic [NUM_RQ-1:0] oh);
      logic [RQ_IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_RQ; i++) begin
         if (oh[i]) idx = RQ_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sdram_arb_rr_sel.sv
// Round-robin selector: search starts just after the last-granted requester.
module sdram_arb_rr_sel
   import sdram_arb_pkg::*;
(
   input  logic [NUM_RQ-1:0]   req,
   input  logic [RQ_IDX_W-1:0] last_gnt,
   output logic [NUM_RQ-1:0]   gnt
);

   logic                found;
   logic [RQ_IDX_W-1:0] pos;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      pos   = '0;
      for (int unsigned i = 1; i <= NUM_RQ; i++) begin
         pos = RQ_IDX_W'((32'(last_gnt) + i) % NUM_RQ);
         if (!found && req[pos]) begin
            gnt[pos] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_wr_arb.sv
// Two-requester round-robin burst write arbiter driving an Avalon-MM SDRAM write port.
// Optional per-requester accepted-beat counters under `define SDRAM_WR_ARB_STATS_EN.
module sdram_wr_arb
   import sdram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 28,
   parameter int unsigned BURST_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,

   input  logic [ADDR_W-1:0]  rq0_address_i,
   input  logic [BURST_W-1:0] rq0_burstcount_i,
   input  logic [DATA_W-1:0]  rq0_writedata_i,
   input  logic [BE_W-1:0]    rq0_byteenable_i,
   input  logic               rq0_write_i,
   output logic               rq0_waitrequest_o,

   input  logic [ADDR_W-1:0]  rq1_address_i,
   input  logic [BURST_W-1:0] rq1_burstcount_i,
   input  logic [DATA_W-1:0]  rq1_writedata_i,
   input  logic [BE_W-1:0]    rq1_byteenable_i,
   input  logic               rq1_write_i,
   output logic               rq1_waitrequest_o,

   output logic [ADDR_W-1:0]  sdram_address_o,
   output logic [BURST_W-1:0] sdram_burstcount_o,
   output logic [DATA_W-1:0]  sdram_writedata_o,
   output logic [BE_W-1:0]    sdram_byteenable_o,
   output logic               sdram_write_o,
   input  logic               sdram_waitrequest_i,

`ifdef SDRAM_WR_ARB_STATS_EN
   input  logic               stats_clr_i,
   output logic [31:0]        rq0_beat_cnt_o,
   output logic [31:0]        rq1_beat_cnt_o,
`endif

   output logic               busy_o
);

   state_t              state;
   logic [RQ_IDX_W-1:0] gnt_idx;
   logic [RQ_IDX_W-1:0] last_gnt;
   logic [RQ_IDX_W-1:0] sel_idx;
   logic [NUM_RQ-1:0]   req;
   logic [NUM_RQ-1:0]   sel;
   logic [BURST_W-1:0]  beat_cnt;
   logic [BURST_W-1:0]  bc_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [BURST_W-1:0]  entry_bc;
   logic [ADDR_W-1:0]   entry_addr;
   logic                accept;

   assign req = {rq1_write_i, rq0_write_i};

   sdram_arb_rr_sel u_rr_sel (
      .req      (req),
      .last_gnt (last_gnt),
      .gnt      (sel)
   );

   assign sel_idx = oh2idx(sel);

   // Burst parameters of the winner; a zero burstcount means one beat.
   always_comb begin
      entry_addr = rq0_address_i;
      entry_bc   = rq0_burstcount_i;
      if (sel_idx == RQ_IDX_W'(1)) begin
         entry_addr = rq1_address_i;
         entry_bc   = rq1_burstcount_i;
      end
      if (entry_bc == '0) entry_bc = BURST_W'(1);
   end

   assign accept = sdram_write_o && !sdram_waitrequest_i;

   // Grant FSM: grant is held until the last beat is accepted.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= IDLE;
         gnt_idx  <= '0;
         last_gnt <= RQ_IDX_W'(1);
         beat_cnt <= '0;
         addr_q   <= '0;
         bc_q     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|req) begin
                  state    <= BURST;
                  gnt_idx  <= sel_idx;
                  beat_cnt <= entry_bc;
                  addr_q   <= entry_addr;
                  bc_q     <= entry_bc;
               end
            end
            BURST: begin
               if (accept) begin
                  if (beat_cnt == BURST_W'(1)) begin
                     state    <= IDLE;
                     last_gnt <= gnt_idx;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt - BURST_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data path follows the granted requester combinationally while in BURST.
   always_comb begin
      sdram_write_o      = 1'b0;
      sdram_writedata_o  = '0;
      sdram_byteenable_o = '0;
      rq0_waitrequest_o  = 1'b1;
      rq1_waitrequest_o  = 1'b1;
      if (state == BURST) begin
         if (gnt_idx == RQ_IDX_W'(0)) begin
            sdram_write_o      = rq0_write_i;
            sdram_writedata_o  = rq0_writedata_i;
            sdram_byteenable_o = rq0_byteenable_i;
            rq0_waitrequest_o  = sdram_waitrequest_i;
         end else begin
            sdram_write_o      = rq1_write_i;
            sdram_writedata_o  = rq1_writedata_i;
            sdram_byteenable_o = rq1_byteenable_i;
            rq1_waitrequest_o  = sdram_waitrequest_i;
         end
      end
   end

   assign sdram_address_o    = addr_q;
   assign sdram_burstcount_o = bc_q;
   assign busy_o             = (state == BURST);

`ifdef SDRAM_WR_ARB_STATS_EN
   // Accepted-beat counters; clear has priority over a same-cycle beat.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rq0_beat_cnt_o <= '0;
         rq1_beat_cnt_o <= '0;
      end else if (stats_clr_i) begin
         rq0_beat_cnt_o <= '0;
         rq1_beat_cnt_o <= '0;
      end else if (accept) begin
         if (gnt_idx == RQ_IDX_W'(0)) rq0_beat_cnt_o <= rq0_beat_cnt_o + 32'd1;
         else                         rq1_beat_cnt_o <= rq1_beat_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sdram_wr_arb.sv
// Scoreboard bench for sdram_wr_arb: drivers queue expected beats, a negedge monitor checks them.
// Build with SDRAM_WR_ARB_STATS_EN defined to also cover the beat counters.
module tb_sdram_wr_arb;

   typedef struct packed {
      logic [127:0] d;
      logic [15:0]  be;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [27:0]  rq_addr [2];
   logic [7:0]   rq_bc   [2];
   logic [127:0] rq_data [2];
   logic [15:0]  rq_be   [2];
   logic         rq_wr   [2];
   logic         rq_wait [2];
   logic [27:0]  sd_addr;
   logic [7:0]   sd_bc;
   logic [127:0] sd_data;
   logic [15:0]  sd_be;
   logic         sd_write;
   logic         sd_wait;
   logic         busy;
`ifdef SDRAM_WR_ARB_STATS_EN
   logic         stats_clr;
   logic [31:0]  cnt0, cnt1;
   logic [31:0]  m_cnt [2];
`endif

   int    total = 0;
   int    bad   = 0;
   beat_t q0[$];
   beat_t q1[$];
   bit    own_log[$];
   int    acc_cnt [2];
   int    busy_cycles;
   bit    rand_wait;

   // Reference model: grant holder, beats left, entry address/burstcount.
   bit          m_busy;
   bit          m_last;
   bit          m_own;
   int          m_rem;
   logic [27:0] m_addr;
   logic [7:0]  m_bc;

   always #5 clk = ~clk;

   sdram_wr_arb dut (
      .clk_i               (clk),
      .rst_n_i             (rst_n),
      .rq0_address_i       (rq_addr[0]),
      .rq0_burstcount_i    (rq_bc[0]),
      .rq0_writedata_i     (rq_data[0]),
      .rq0_byteenable_i    (rq_be[0]),
      .rq0_write_i         (rq_wr[0]),
      .rq0_waitrequest_o   (rq_wait[0]),
      .rq1_address_i       (rq_addr[1]),
      .rq1_burstcount_i    (rq_bc[1]),
      .rq1_writedata_i     (rq_data[1]),
      .rq1_byteenable_i    (rq_be[1]),
      .rq1_write_i         (rq_wr[1]),
      .rq1_waitrequest_o   (rq_wait[1]),
      .sdram_address_o     (sd_addr),
      .sdram_burstcount_o  (sd_bc),
      .sdram_writedata_o   (sd_data),
      .sdram_byteenable_o  (sd_be),
      .sdram_write_o       (sd_write),
      .sdram_waitrequest_i (sd_wait),
`ifdef SDRAM_WR_ARB_STATS_EN
      .stats_clr_i         (stats_clr),
      .rq0_beat_cnt_o      (cnt0),
      .rq1_beat_cnt_o      (cnt1),
`endif
      .busy_o              (busy)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one burst on requester k; each beat's expectation is queued before it is offered.
   task automatic drive_burst(input bit k, input logic [7:0] bc, input bit stalls);
      int    n;
      int    guard;
      logic  acc;
      beat_t b;
      n = (bc == 8'd0) ? 1 : int'(bc);
      rq_addr[k] = 28'($urandom);
      rq_bc[k]   = bc;
      for (int i = 0; i < n; i++) begin
         b.d  = {$urandom, $urandom, $urandom, $urandom};
         b.be = 16'($urandom);
         if (k == 1'b0) q0.push_back(b); else q1.push_back(b);
         if (stalls && i > 0 && $urandom_range(3, 0) == 0) begin
            rq_wr[k] = 1'b0;
            repeat ($urandom_range(2, 1)) @(posedge clk);
            #1;
         end
         rq_data[k] = b.d;
         rq_be[k]   = b.be;
         rq_wr[k]   = 1'b1;
         guard = 0;
         acc   = 1'b0;
         while (!acc && guard < 1000) begin
            @(negedge clk);
            acc = rq_wr[k] && !rq_wait[k];
            @(posedge clk);
            #1;
            guard++;
         end
         if (!acc) check("beat_timeout", 128'(guard), 128'(0));
         // Scramble the request fields: the arbiter must hold its entry values.
         if (i == 0) begin
            rq_addr[k] = 28'($urandom);
            rq_bc[k]   = 8'($urandom);
         end
      end
      rq_wr[k] = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((m_busy || q0.size() != 0 || q1.size() != 0) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) check("idle_timeout", 128'(guard), 128'(0));
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input bit k, input int target);
      int guard;
      guard = 0;
      while (acc_cnt[k] < target && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 500) check("acc_timeout", 128'(acc_cnt[k]), 128'(target));
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares the DUT against the model in the cycle about to close.
   always @(negedge clk) begin
      bit    acc_now;
      beat_t b;
      acc_now = 1'b0;
      if (!rst_n) begin
         m_busy = 1'b0;
         m_last = 1'b1;
         m_rem  = 0;
`ifdef SDRAM_WR_ARB_STATS_EN
         m_cnt[0] = 32'd0;
         m_cnt[1] = 32'd0;
`endif
      end else begin
         if (!m_busy) begin
            check("idle_write", 128'(sd_write), 128'(0));
            check("idle_busy", 128'(busy), 128'(0));
            check("idle_wait0", 128'(rq_wait[0]), 128'(1));
            check("idle_wait1", 128'(rq_wait[1]), 128'(1));
            if (rq_wr[0] || rq_wr[1]) begin
               m_own  = (rq_wr[0] && rq_wr[1]) ? ~m_last : rq_wr[1];
               m_busy = 1'b1;
               m_bc   = (rq_bc[m_own] == 8'd0) ? 8'd1 : rq_bc[m_own];
               m_rem  = int'(m_bc);
               m_addr = rq_addr[m_own];
               own_log.push_back(m_own);
            end
         end else begin
            busy_cycles++;
            check("burst_busy", 128'(busy), 128'(1));
            check("burst_addr", 128'(sd_addr), 128'(m_addr));
            check("burst_count", 128'(sd_bc), 128'(m_bc));
            check("burst_write", 128'(sd_write), 128'(rq_wr[m_own]));
            check("grant_wait", 128'(rq_wait[m_own]), 128'(sd_wait));
            check("other_wait", 128'(rq_wait[~m_own]), 128'(1));
            if (rq_wr[m_own] && !sd_wait) begin
               acc_now = 1'b1;
               acc_cnt[m_own]++;
               if (m_own == 1'b0) begin
                  check("rq0_beat_pending", 128'(q0.size() > 0), 128'(1));
                  if (q0.size() > 0) b = q0.pop_front();
               end else begin
                  check("rq1_beat_pending", 128'(q1.size() > 0), 128'(1));
                  if (q1.size() > 0) b = q1.pop_front();
               end
               check("beat_data", sd_data, b.d);
               check("beat_be", 128'(sd_be), 128'(b.be));
               m_rem--;
               if (m_rem == 0) begin
                  m_busy = 1'b0;
                  m_last = m_own;
               end
            end
         end
`ifdef SDRAM_WR_ARB_STATS_EN
         check("stats_rq0", 128'(cnt0), 128'(m_cnt[0]));
         check("stats_rq1", 128'(cnt1), 128'(m_cnt[1]));
         if (stats_clr) begin
            m_cnt[0] = 32'd0;
            m_cnt[1] = 32'd0;
         end else if (acc_now) begin
            m_cnt[m_own] = m_cnt[m_own] + 32'd1;
         end
`endif
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_wait) sd_wait = ($urandom_range(3, 0) == 0);
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      logic [3:0] pat;
      beat_t b;
      rst_n     = 1'b0;
      sd_wait   = 1'b0;
      rand_wait = 1'b0;
      acc_cnt[0] = 0;
      acc_cnt[1] = 0;
      busy_cycles = 0;
      for (int k = 0; k < 2; k++) begin
         rq_addr[k] = '0;
         rq_bc[k]   = '0;
         rq_data[k] = '0;
         rq_be[k]   = '0;
         rq_wr[k]   = 1'b0;
      end
`ifdef SDRAM_WR_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_write", 128'(sd_write), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_wait0", 128'(rq_wait[0]), 128'(1));
      check("rst_wait1", 128'(rq_wait[1]), 128'(1));
      check("rst_addr", 128'(sd_addr), 128'(0));
      check("rst_bc", 128'(sd_bc), 128'(0));
      check("rst_data", sd_data, 128'(0));
      check("rst_be", 128'(sd_be), 128'(0));
`ifdef SDRAM_WR_ARB_STATS_EN
      check("rst_cnt0", 128'(cnt0), 128'(0));
      check("rst_cnt1", 128'(cnt1), 128'(0));
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single requester, 4 beats, no stall.
      busy_cycles = 0;
      base = acc_cnt[0];
      drive_burst(1'b0, 8'd4, 1'b0);
      wait_idle();
      check("s1_busy_cycles", 128'(busy_cycles), 128'(4));
      check("s1_beats", 128'(acc_cnt[0] - base), 128'(4));

      // Simultaneous requests from reset: rq0, rq1, then rq0 again.
      pulse_reset();
      own_log.delete();
      fork
         drive_burst(1'b0, 8'd2, 1'b0);
         drive_burst(1'b1, 8'd2, 1'b0);
      join
      wait_idle();
      fork
         drive_burst(1'b0, 8'd2, 1'b0);
         drive_burst(1'b1, 8'd2, 1'b0);
      join
      wait_idle();
      check("s2_grant_count", 128'(own_log.size()), 128'(4));
      pat = '0;
      for (int i = 0; i < 4; i++) if (i < own_log.size()) pat[3-i] = own_log[i];
      check("s2_grant_order", 128'(pat), 128'(4'b0101));

      // Two-cycle slave stall on beat 2 of 3.
      base = acc_cnt[0];
      fork
         drive_burst(1'b0, 8'd3, 1'b0);
         begin
            wait_acc(1'b0, base + 1);
            sd_wait = 1'b1;
            @(negedge clk);
            check("s3_stall_wait", 128'(rq_wait[0]), 128'(1));
            check("s3_stall_write", 128'(sd_write), 128'(1));
            @(posedge clk);
            @(posedge clk);
            #1;
            sd_wait = 1'b0;
         end
      join
      wait_idle();
      check("s3_beats", 128'(acc_cnt[0] - base), 128'(3));

      // Burstcount 0 behaves as one beat.
      base = acc_cnt[1];
      drive_burst(1'b1, 8'd0, 1'b0);
      wait_idle();
      check("s4_beats", 128'(acc_cnt[1] - base), 128'(1));
      check("s4_idle", 128'(busy), 128'(0));

      // Reset during beat 2 of an 8-beat burst.
      base = acc_cnt[0];
      b.d  = {$urandom, $urandom, $urandom, $urandom};
      b.be = 16'hffff;
      for (int i = 0; i < 8; i++) q0.push_back(b);
      rq_addr[0] = 28'h0abcdef;
      rq_bc[0]   = 8'd8;
      rq_data[0] = b.d;
      rq_be[0]   = b.be;
      rq_wr[0]   = 1'b1;
      wait_acc(1'b0, base + 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("s5_write_drop", 128'(sd_write), 128'(0));
      check("s5_busy_drop", 128'(busy), 128'(0));
      check("s5_wait0", 128'(rq_wait[0]), 128'(1));
      check("s5_addr", 128'(sd_addr), 128'(0));
      rq_wr[0] = 1'b0;
      q0.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      own_log.delete();
      base = acc_cnt[1];
      drive_burst(1'b1, 8'd2, 1'b0);
      wait_idle();
      check("s5_rq1_beats", 128'(acc_cnt[1] - base), 128'(2));
      check("s5_rq1_grant", 128'(own_log.size() == 1 && own_log[0] == 1'b1), 128'(1));

`ifdef SDRAM_WR_ARB_STATS_EN
      // Clear coinciding with the third of five accepted beats.
      pulse_reset();
      base = acc_cnt[0];
      fork
         drive_burst(1'b0, 8'd5, 1'b0);
         begin
            wait_acc(1'b0, base + 2);
            stats_clr = 1'b1;
            @(posedge clk);
            #1;
            stats_clr = 1'b0;
            @(negedge clk);
            check("s6_cleared", 128'(cnt0), 128'(0));
         end
      join
      wait_idle();
      check("s6_cnt0", 128'(cnt0), 128'(2));
`endif

      // Randomized traffic with slave stalls and requester pauses.
      rand_wait = 1'b1;
      fork
         for (int n = 0; n < 15; n++) begin
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
            drive_burst(1'b0, 8'($urandom_range(6, 0)), 1'b1);
         end
         for (int n = 0; n < 15; n++) begin
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
            drive_burst(1'b1, 8'($urandom_range(6, 0)), 1'b1);
         end
      join
      rand_wait = 1'b0;
      sd_wait   = 1'b0;
      wait_idle();
      check("end_q0_empty", 128'(q0.size()), 128'(0));
      check("end_q1_empty", 128'(q1.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdram_wr_arb.md
SDRAM_WR_ARB -- requirements
Module: sdram_wr_arb

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 28, master and requester word-address width.
REQ-002 The block SHALL expose parameter BURST_W, default 8, burstcount width.
REQ-003 The block SHALL expose clk_i  input  1  single clock for all logic.
REQ-004 The block SHALL expose rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 For each requester k in {0,1}, the block SHALL expose rqk_address_i  input  ADDR_W  burst start address.
REQ-006 For each k, the block SHALL expose rqk_burstcount_i  input  BURST_W  beats in burst.
REQ-007 For each k, the block SHALL expose rqk_writedata_i  input  128  beat data.
REQ-008 For each k, the block SHALL expose rqk_byteenable_i  input  16  beat byte enables.
REQ-009 For each k, the block SHALL expose rqk_write_i  input  1  beat valid.
REQ-010 For each k, the block SHALL expose rqk_waitrequest_o  output  1  beat not accepted.
REQ-011 The block SHALL expose sdram_address_o  output  ADDR_W, sdram_burstcount_o  output  BURST_W, sdram_writedata_o  output  128, sdram_byteenable_o  output  16, sdram_write_o  output  1: the Avalon-MM write master toward the FPGA-to-SDRAM port.
REQ-012 The block SHALL expose sdram_waitrequest_i  input  1  slave stall.
REQ-013 The block SHALL expose busy_o  output  1  high whenever a grant is held.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-015 In IDLE, sdram_write_o SHALL be 0 and both rqk_waitrequest_o SHALL be 1.
REQ-016 In IDLE with at least one rqk_write_i high, the FSM SHALL register a grant and enter BURST on the next edge; grant-to-first-beat latency is one cycle.
REQ-017 Arbitration SHALL be round-robin: the requester not granted last wins ties; a single requester wins unconditionally.
REQ-018 In BURST, sdram_* outputs SHALL be driven from the granted requester, and its waitrequest SHALL equal sdram_waitrequest_i; the other requester's waitrequest SHALL be 1.
REQ-019 On BURST entry the beat counter SHALL load the granted rqk_burstcount_i, with 0 treated as 1; sdram_address_o and sdram_burstcount_o SHALL be held from that entry value for the whole burst.
REQ-020 A beat SHALL be accepted when sdram_write_o && !sdram_waitrequest_i; each accepted beat decrements the counter.
REQ-021 A deasserted granted write mid-burst SHALL stall the burst without releasing the grant.
REQ-022 Acceptance of the last beat SHALL return the FSM to IDLE and update the last-grant pointer; back-to-back bursts therefore incur one idle cycle.
REQ-023 busy_o SHALL equal (state == BURST).

Reset
REQ-024 Asserting rst_n_i SHALL, asynchronously, force IDLE, counter 0, last-grant pointer = 1 (requester 0 first), sdram_write_o 0, busy_o 0, rqk_waitrequest_o 1, and all other outputs 0, including in mid-burst.

Configuration
REQ-025 With macro SDRAM_WR_ARB_STATS_EN defined, the block SHALL add stats_clr_i  input  1 and rq0_beat_cnt_o/rq1_beat_cnt_o  output  32: per-requester accepted-beat counters that wrap at 2^32, are synchronously cleared by stats_clr_i (clear wins over a simultaneous increment), and reset to 0.
REQ-026 Without SDRAM_WR_ARB_STATS_EN, those ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-027 Package sdram_arb_pkg SHALL hold the state enum (IDLE, BURST), the data-width constant 128, the byte-enable-width constant 16 and the requester count 2.
REQ-028 The round-robin selection SHALL be the sub-module sdram_arb_rr_sel: inputs are the request vector and last-grant pointer; output is a one-hot grant.

Verification
REQ-029 Bench scenario: rq0 only, burstcount 4, waitrequest 0 -> grant after 1 cycle, 4 consecutive beats, busy_o high for 4 cycles, then IDLE.
REQ-030 Bench scenario: rq0 and rq1 both request burstcount 2 from reset -> rq0 served first, then rq1 after one idle cycle; next simultaneous request -> rq0 wins again.
REQ-031 Bench scenario: burstcount 3 with sdram_waitrequest_i high for 2 cycles on beat 2 -> granted waitrequest mirrors the stall, address held, exactly 3 beats accepted.
REQ-032 Bench scenario: burstcount 0 -> single beat accepted, FSM back in IDLE.
REQ-033 Bench scenario: rst_n_i low mid-burst (beat 2 of 8) -> sdram_write_o drops immediately; after release, a new rq1 request is granted normally.
REQ-034 Bench scenario, SDRAM_WR_ARB_STATS_EN defined: 5 rq0 beats plus stats_clr_i pulsed on a beat-accept cycle -> rq0_beat_cnt_o reads 0 after the clear and increments on later beats only.
